// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, op-code constants and default widths for the switch ALU.
package alu_pkg;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_OP_W = 2;
  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    ISSUE   = 2'b11
  } state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser, level debounce and registered rising-edge pulse.
module switch_debouncer #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);
  logic sync1_q, sync2_q, settle;
  logic [7:0] cnt_q;
  assign settle = (sync2_q != clean) && (cnt_q == 8'(DEBOUNCE - 1));
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= (sync2_q == clean || settle) ? '0 : cnt_q + 8'd1;
      clean   <= settle ? sync2_q : clean;
      rise    <= settle && sync2_q;
    end
  end
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads A, B and op from one switch field via a debounced enter key
// and presents the triple to the ALU over a valid/ready handshake.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OP_W     = DEF_OP_W,
  parameter int DEBOUNCE = 2,
  parameter int CNT_W    = 4
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [DATA_W-1:0] swi_data,
  input  logic              enter,
  input  logic              clear,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  op_count
);
  state_t state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0] op_q;
  logic valid_q, enter_clean, enter_rise, press;
  logic [CNT_W-1:0] cnt_q;
  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_enter (
    .clk_2(clk_2),
    .reset(reset),
    .raw  (enter),
    .clean(enter_clean),
    .rise (enter_rise)
  );
  // rise is only ever raised together with clean, so this just qualifies the pulse
  assign press = enter_rise && enter_clean;
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (clear) begin
      state_q <= LOAD_A;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (press) begin
          a_q     <= swi_data;
          state_q <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b_q     <= swi_data;
          state_q <= LOAD_OP;
        end
        LOAD_OP: if (press) begin
          op_q    <= swi_data[OP_W-1:0];
          valid_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: if (valid_q && op_ready) begin
          cnt_q   <= cnt_q + 1'b1;
          valid_q <= 1'b0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end
  assign op_valid  = valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign state_out = state_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized directed sequence checked against an entry-step model.
module tb_alu_operand_sequencer;
  logic clk_2 = 1'b0, reset = 1'b1, enter = 1'b0, clear = 1'b0, op_ready = 1'b0;
  logic [2:0] swi_data = '0;
  logic op_valid;
  logic [2:0] a_out, b_out;
  logic [1:0] op_out, state_out;
  logic [3:0] op_count;
  int total = 0, passed = 0;
  int m_step, m_a, m_b, m_op, m_cnt;
  alu_operand_sequencer #(.DATA_W(3), .OP_W(2), .DEBOUNCE(2), .CNT_W(4)) dut (
    .clk_2(clk_2), .reset(reset), .swi_data(swi_data), .enter(enter), .clear(clear),
    .op_ready(op_ready), .op_valid(op_valid), .a_out(a_out), .b_out(b_out),
    .op_out(op_out), .state_out(state_out), .op_count(op_count)
  );
  always #5 clk_2 = ~clk_2;
  task automatic tick(int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask
  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic check_all(string tag);
    chk({tag, ".state"}, int'(state_out), m_step);
    chk({tag, ".valid"}, int'(op_valid), int'(m_step == 3));
    chk({tag, ".a"}, int'(a_out), m_a);
    chk({tag, ".b"}, int'(b_out), m_b);
    chk({tag, ".op"}, int'(op_out), m_op);
    chk({tag, ".count"}, int'(op_count), m_cnt);
  endtask
  task automatic m_reset();
    m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
  endtask
  task automatic m_press(int d);
    if (m_step == 0) m_a = d;
    if (m_step == 1) m_b = d;
    if (m_step == 2) m_op = d % 4;
    if (m_step < 3) m_step++;
  endtask
  task automatic m_handshake();
    if (m_step == 3) begin
      m_cnt = (m_cnt + 1) % 16;
      m_step = 0;
    end
  endtask
  task automatic press_entry(logic [2:0] d, bit rnd_ready);
    swi_data = d;
    op_ready = rnd_ready ? 1'($urandom) : 1'b0;
    enter = 1'b1;
    tick(6);
    swi_data = 3'($urandom);
    enter = 1'b0;
    tick(6);
    op_ready = 1'b0;
    m_press(int'(d));
  endtask
  task automatic load_triple();
    press_entry(3'($urandom), 1'b1);
    press_entry(3'($urandom), 1'b1);
    press_entry(3'($urandom), 1'b0);
  endtask
  task automatic handshake();
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    m_handshake();
  endtask
  initial begin
    m_reset();
    tick(3);
    reset = 1'b0;
    tick(10);
    check_all("idle");
    // first capture lands on the fourth edge after enter is first sampled
    swi_data = 3'b101;
    enter = 1'b1;
    tick(4);
    chk("latency.before", int'(state_out), 0);
    tick(1);
    chk("latency.at", int'(state_out), 1);
    chk("latency.a", int'(a_out), 5);
    tick(1);
    enter = 1'b0;
    tick(6);
    m_press(5);
    press_entry(3'b010, 1'b0);
    press_entry(3'b001, 1'b0);
    check_all("issue");
    for (int i = 0; i < 5; i++) begin
      enter = 1'($urandom);
      swi_data = 3'($urandom);
      tick(1);
      check_all("hold");
    end
    enter = 1'b0;
    tick(8);
    check_all("hold.settled");
    handshake();
    check_all("handshake1");
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
    tick(8);
    check_all("glitch");
    swi_data = 3'b110;
    enter = 1'b1; tick(1);
    enter = 1'b0; tick(1);
    enter = 1'b1; tick(8);
    swi_data = 3'($urandom);
    enter = 1'b0; tick(8);
    m_press(6);
    check_all("bounce");
    press_entry(3'($urandom), 1'b1);
    enter = 1'b1;
    swi_data = 3'b111;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_step = 0;
    check_all("clear.press");
    enter = 1'b0;
    tick(8);
    check_all("clear.settled");
    load_triple();
    check_all("issue2");
    op_ready = 1'b1;
    clear = 1'b1;
    tick(1);
    op_ready = 1'b0;
    clear = 1'b0;
    m_step = 0;
    check_all("clear.ready");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 16; i++) begin
      load_triple();
      check_all("txn.issue");
      op_ready = 1'b0;
      tick($urandom_range(0, 3));
      handshake();
      check_all("txn.done");
    end
    chk("wrap", int'(op_count), 0);
    press_entry(3'($urandom), 1'b1);
    check_all("loadb");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_reset();
    check_all("reset.loadb");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
